alu_exec_unit: RTL

Parametrised, handshaked execute stage for the MIPS datapath that merges ALU-control decode (ALUOp + funct) with a registered ALU. Single-cycle operations complete with one cycle of latency. A multi-cycle unsigned multiply (MULTU) produces a double-width HI/LO result. It sits between the ID/EX register and the EX/MEM register and replaces the purely combinational control-decode-plus-ALU path with a valid/ready stage.

---
 rtl/alu_exec_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode plus registered ALU behind a valid/ready handshake.
// Single-cycle ops have one cycle of latency; MULTU runs a WIDTH-step shift-add multiply.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic [3:0]       op_code,
    output logic             illegal
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(WIDTH);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpMul = 4'b1000;
    localparam logic [3:0] OpNor = 4'b1100;
    localparam logic [3:0] OpXor = 4'b1101;
    localparam logic [3:0] OpIll = 4'b1111;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e state_q, state_d;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CntW-1:0]    count_q;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic [3:0]       op_code_q, op_code_d;
    logic             illegal_q, illegal_d;

    logic [3:0]         dec_op;
    logic [WIDTH-1:0]   alu_res;
    logic               slt_bit;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] product;
    logic               mul_done;
    logic               can_load;
    logic               accept;
    logic               mul_start;
    logic               mul_step;
    logic               load_single;
    logic               load_mul;

    // Opcode decode from ALUOp and funct.
    always_comb begin
        dec_op = OpIll;
        unique case (alu_op)
            2'b00: dec_op = OpAdd;
            2'b01: dec_op = OpSub;
            2'b11: dec_op = OpSlt;
            2'b10: begin
                case (funct)
                    6'd32:   dec_op = OpAdd;
                    6'd34:   dec_op = OpSub;
                    6'd36:   dec_op = OpAnd;
                    6'd37:   dec_op = OpOr;
                    6'd38:   dec_op = OpXor;
                    6'd39:   dec_op = OpNor;
                    6'd42:   dec_op = OpSlt;
                    6'd25:   dec_op = OpMul;
                    default: dec_op = OpIll;
                endcase
            end
            default: dec_op = OpIll;
        endcase
    end

    assign slt_bit = $signed(a) < $signed(b);

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpAdd:   alu_res = a + b;
            OpSub:   alu_res = a - b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OpNor:   alu_res = ~(a | b);
            OpXor:   alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_done = (count_q >= CntLast);
    // Once saturated the accumulator already holds the full product.
    assign product  = (count_q == CntMax) ? acc_q : acc_step;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mul_start) state_d = StMul;
            StMul:  if (load_mul) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake and datapath control.
    always_comb begin
        can_load    = !out_valid_q || out_ready;
        in_ready    = (state_q == StIdle) && can_load;
        accept      = in_valid && in_ready;
        mul_start   = accept && (dec_op == OpMul);
        load_single = accept && (dec_op != OpMul);
        load_mul    = (state_q == StMul) && mul_done && can_load;
        mul_step    = (state_q == StMul) && (count_q != CntMax);
    end

    // Shift-add multiplier: one partial product per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (mul_start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (mul_step) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CntW'(1);
        end
    end

    // Output register next-state; registers hold unless a result loads.
    always_comb begin
        out_valid_d = (out_valid_q && !out_ready) || load_single || load_mul;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        op_code_d   = op_code_q;
        illegal_d   = illegal_q;
        zero_d      = zero_q;
        if (load_single) begin
            result_d    = alu_res;
            result_hi_d = '0;
            op_code_d   = dec_op;
            illegal_d   = (dec_op == OpIll);
            zero_d      = (alu_res == '0);
        end else if (load_mul) begin
            result_d    = product[WIDTH-1:0];
            result_hi_d = product[2*WIDTH-1:WIDTH];
            op_code_d   = OpMul;
            illegal_d   = 1'b0;
            zero_d      = (product == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            op_code_q   <= OpAnd;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            op_code_q   <= op_code_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign op_code   = op_code_q;
    assign illegal   = illegal_q;

endmodule
